ahb_lite_burst_master: RTL and testbench
========================================

Name: ahb_lite_burst_master

Overview:
- Parametrised AHB-Lite master; the next generation of the single-beat AHB master.
- Converts one request (address, direction, size, beat count) into a fully pipelined SINGLE or INCR burst.
- Overlaps beat n address phase with beat n-1 data phase; write data is flow-controlled with BUSY insertion.
- Handles wait states, the two-cycle ERROR response and 1KB boundary restarts. Sits between the DMA/bridge logic and the AHB interconnect.

Parameters:
- DATA_WIDTH, 32, HWDATA/HRDATA width (32 or 64).
- ADDR, 32, HADDR width.
- MAX_BEATS, 16, maximum beats per request; LEN_W = clog2(MAX_BEATS).

Ports:
- i_clk_ahb  in  1  AHB clock.
- i_rstn_ahb  in  1  Reset; asynchronous, active-low.
- i_valid  in  1  Request valid.
- o_ready  out  1  Request accepted when i_valid && o_ready.
- i_addr  in  ADDR  Start address; must be aligned to i_size.
- i_rd0_wr1  in  1  0 = read, 1 = write.
- i_size  in  3  HSIZE for every beat; values above log2(DATA_WIDTH/8) are clipped to that maximum.
- i_len  in  LEN_W  Beats minus 1.
- i_wr_data  in  DATA_WIDTH  Write beat data.
- i_wr_valid  in  1  Write beat available.
- o_wr_ready  out  1  Write beat consumed when i_wr_valid && o_wr_ready.
- o_rd_data  out  DATA_WIDTH  Registered read beat.
- o_rd_valid  out  1  One-cycle pulse per good read beat; no backpressure.
- o_done  out  1  One-cycle pulse at end of request.
- o_err  out  1  Valid with o_done; 1 = request ended on ERROR.
- o_haddr, o_htrans[1:0], o_hwrite, o_hsize[2:0], o_hburst[2:0], o_hprot[3:0], o_hmastlock, o_hwdata  out  AHB-Lite master signals.
- i_hready, i_hresp, i_hrdata  in  AHB-Lite slave response.

Behaviour:
- Reset: all outputs 0, except o_hprot = 4'b0011 (constant) and o_ready = 1. o_hmastlock is always 0. State returns to IDLE; the in-flight transfer is abandoned with no o_done.
- States:
  - IDLE: o_ready = 1, HTRANS = IDLE. On accept, latch the request and go to ADDR.
  - ADDR: drives address phases (NONSEQ/SEQ/BUSY). Leaves after the last address phase is accepted (i_hready = 1).
  - LAST: final data phase only.
  - ERR: second ERROR cycle.
- Address phase advances only when i_hready = 1; all AHB outputs are held while i_hready = 0.
- HTRANS selection:
  - First beat is NONSEQ.
  - Subsequent beats are SEQ.
  - A beat whose address lands on a 1KB boundary (addr[9:0] == 0, not the first beat) is issued as NONSEQ.
  - Beat address = previous + (1 << size); no wrap.
- HBURST = SINGLE (000) when i_len = 0, else INCR (001). HSIZE and HWRITE are constant for the request.
- Write flow:
  - Each beat's data is popped (o_wr_ready = 1) in the cycle its address phase is accepted, and registered to o_hwdata for the following data phase.
  - First beat: HTRANS stays IDLE while i_wr_valid = 0.
  - Later beats: HTRANS = BUSY at the next address while i_wr_valid = 0, then SEQ (or NONSEQ at a 1KB boundary) once data arrives.
  - o_hwdata is held through wait states.
- Read flow: o_rd_data/o_rd_valid are registered the cycle after a data phase completes with i_hready = 1 and i_hresp = 0.
- Completion: o_done pulses one cycle after the final data phase completes, coincident with the final o_rd_valid for reads. o_ready rises in that same cycle. Minimum request-to-request gap is 1 idle cycle.
- ERROR (i_hresp = 1):
  - Cycle 1 (i_hready = 0): drive HTRANS = IDLE this cycle, cancelling any pending address.
  - Cycle 2 (i_hready = 1): enter ERR. Remaining beats are dropped, no further o_wr_ready is issued, and no o_rd_valid is produced for the failed beat.
  - Next cycle: o_done = 1, o_err = 1, return to IDLE.
- A new request is never accepted while a transfer is outstanding.
- Throughput: back-to-back beats with zero wait states give N beats in N + 1 bus cycles; o_done follows one cycle later.

Test Plan:
- Write 0x100, len = 0, data 0xA5A5A5A5, one wait state -> NONSEQ/SINGLE at 0x100, hwdata held 2 cycles, o_done = 1, o_err = 0.
- Read INCR4 at 0x200, size = 2, zero waits, hrdata 1..4 -> haddr 0x200/204/208/20C as NONSEQ, SEQ, SEQ, SEQ; o_rd_valid on 4 consecutive cycles with 1..4; o_done with the last beat.
- Write 4 beats with i_wr_valid low 2 cycles before beat 3 -> HTRANS shows 2 BUSY cycles at 0x208, then SEQ; hwdata order intact.
- Read 4 beats at 0x3F8 -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
- ERROR on beat 2 of 8-beat write -> HTRANS = IDLE in the first ERROR cycle, no beats 3..8 issued, o_done = o_err = 1, o_ready high next cycle.
- Assert i_rstn_ahb low mid-burst -> all outputs at reset values immediately; a subsequent request completes normally.

Source files
------------

// File: rtl/ahb_lite_burst_master.sv
// AHB-Lite burst master: turns one request into a pipelined SINGLE/INCR burst
// with write-side BUSY insertion, wait states, two-cycle ERROR and 1KB restarts.
module ahb_lite_burst_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR       = 32,
  parameter int unsigned MAX_BEATS  = 16,
  localparam int unsigned LEN_W     = $clog2(MAX_BEATS)
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR-1:0]       i_addr,
  input  logic                  i_rd0_wr1,
  input  logic [2:0]            i_size,
  input  logic [LEN_W-1:0]      i_len,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR-1:0]       o_haddr,
  output logic [1:0]            o_htrans,
  output logic                  o_hwrite,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [3:0]            o_hprot,
  output logic                  o_hmastlock,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic                  i_hready,
  input  logic                  i_hresp,
  input  logic [DATA_WIDTH-1:0] i_hrdata
);

  localparam logic [2:0] SizeMax     = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  typedef enum logic [1:0] {StIdle, StAddr, StLast, StErr} state_e;

  state_e                state_q, state_d;
  logic [ADDR-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  first_q, first_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [2:0]            hburst_q, hburst_d;
  logic                  dp_q, dp_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [1:0]      htrans;
  logic            wr_ready;
  logic            beat_ok;
  logic            ahb_err;
  logic [ADDR-1:0] incr;

  assign incr    = ADDR'(1) << hsize_q;
  // ERROR only matters while one of our data phases is on the bus
  assign ahb_err = dp_q && i_hresp;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    dp_d       = dp_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    htrans     = TransIdle;
    wr_ready   = 1'b0;
    beat_ok    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          addr_d   = i_addr;
          cnt_d    = i_len;
          first_d  = 1'b1;
          hwrite_d = i_rd0_wr1;
          hsize_d  = (i_size > SizeMax) ? SizeMax : i_size;
          hburst_d = (i_len == '0) ? 3'b000 : 3'b001;
          state_d  = StAddr;
        end
      end
      StAddr: begin
        beat_ok = !hwrite_q || i_wr_valid;
        if (!ahb_err) begin
          if (beat_ok) begin
            htrans = (first_q || addr_q[9:0] == 10'd0) ? TransNonseq : TransSeq;
          end else begin
            htrans = first_q ? TransIdle : TransBusy;
          end
          wr_ready = hwrite_q && i_wr_valid && i_hready;
        end
        if (ahb_err && !i_hready) begin
          state_d = StErr;
          dp_d    = 1'b0;
        end else if (i_hready && !ahb_err) begin
          dp_d = beat_ok;
          if (beat_ok) begin
            addr_d  = addr_q + incr;
            first_d = 1'b0;
            if (cnt_q == '0) begin
              state_d = StLast;
            end else begin
              cnt_d = cnt_q - LEN_W'(1);
            end
          end
        end
      end
      StLast: begin
        if (i_hresp && !i_hready) begin
          state_d = StErr;
          dp_d    = 1'b0;
        end else if (i_hready) begin
          state_d = StIdle;
          dp_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = i_hresp;
        end
      end
      StErr: begin
        state_d = StIdle;
        dp_d    = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (dp_q && i_hready && !i_hresp && !hwrite_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = i_hrdata;
    end
    if (wr_ready) begin
      hwdata_d = i_wr_data;
    end
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'd0;
      hburst_q   <= 3'd0;
      dp_q       <= 1'b0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      dp_q       <= dp_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_ready     = (state_q == StIdle);
  assign o_wr_ready  = wr_ready;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_haddr     = addr_q;
  assign o_htrans    = htrans;
  assign o_hwrite    = hwrite_q;
  assign o_hsize     = hsize_q;
  assign o_hburst    = hburst_q;
  assign o_hprot     = 4'b0011;
  assign o_hmastlock = 1'b0;
  assign o_hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Bench for ahb_lite_burst_master: directed and random requests against a
// beat-level bus model acting as the AHB slave and expected-value source.
module tb_ahb_lite_burst_master;

  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_addr = '0;
  logic        i_rd0_wr1 = 1'b0;
  logic [2:0]  i_size = '0;
  logic [3:0]  i_len = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic [31:0] o_rd_data;
  logic        o_rd_valid, o_done, o_err;
  logic [31:0] o_haddr;
  logic [1:0]  o_htrans;
  logic        o_hwrite;
  logic [2:0]  o_hsize, o_hburst;
  logic [3:0]  o_hprot;
  logic        o_hmastlock;
  logic [31:0] o_hwdata;
  logic        i_hready = 1'b1;
  logic        i_hresp = 1'b0;
  logic [31:0] i_hrdata = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] dat [16];

  always #5 clk = ~clk;

  ahb_lite_burst_master #(.DATA_WIDTH(32), .ADDR(32), .MAX_BEATS(16)) dut (
    .i_clk_ahb(clk), .i_rstn_ahb(rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_rd0_wr1(i_rd0_wr1), .i_size(i_size), .i_len(i_len),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_done(o_done), .o_err(o_err),
    .o_haddr(o_haddr), .o_htrans(o_htrans), .o_hwrite(o_hwrite), .o_hsize(o_hsize),
    .o_hburst(o_hburst), .o_hprot(o_hprot), .o_hmastlock(o_hmastlock),
    .o_hwdata(o_hwdata), .i_hready(i_hready), .i_hresp(i_hresp), .i_hrdata(i_hrdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit seq, input logic [31:0] d0);
    for (int k = 0; k < 16; k++) dat[k] = seq ? d0 + 32'(k) : $urandom;
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", o_ready, 1);
    check("rst_htrans", o_htrans, 0);
    check("rst_haddr", o_haddr, 0);
    check("rst_hwrite", o_hwrite, 0);
    check("rst_hsize", o_hsize, 0);
    check("rst_hburst", o_hburst, 0);
    check("rst_hprot", o_hprot, 4'b0011);
    check("rst_hmastlock", o_hmastlock, 0);
    check("rst_hwdata", o_hwdata, 0);
    check("rst_wr_ready", o_wr_ready, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
  endtask

  // One request; the bench plays the slave and predicts every bus cycle.
  // waits < 0: random 0..2 per data phase. err_beat < 0: no ERROR.
  task automatic run_req(input logic [31:0] start, input bit wr, input logic [2:0] size,
                         input int len, input int waits, input int err_beat,
                         input bit rand_wv, input int gap_beat, input int gap_len,
                         input int stop_after, output int cycles, output int busy);
    int sc = (size > 3'd2) ? 2 : int'(size);
    int nb = len + 1;
    int na = 0;
    int dp = -1;
    int dpw = 0;
    int gap = gap_len;
    bit aborted = 1'b0;
    bit issuing;
    bit exp_rdv = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [31:0] ea;
    logic [1:0] et;
    bit hr, hp, wv = 1'b0;
    cycles = 0;
    busy = 0;
    i_valid = 1'b1; i_addr = start; i_rd0_wr1 = wr; i_size = size; i_len = 4'(len);
    i_wr_valid = 1'b0; i_hready = 1'b1; i_hresp = 1'b0;
    #1;
    check("req_ready", o_ready, 1);
    check("req_htrans", o_htrans, TI);
    tick();
    i_valid = 1'b0;
    forever begin
      cycles++;
      check("rd_valid", o_rd_valid, exp_rdv);
      if (exp_rdv) check("rd_data", o_rd_data, exp_rd);
      check("done", o_done, exp_done);
      check("ready", o_ready, exp_done);
      if (exp_done) begin
        check("err", o_err, exp_err);
        check("end_htrans", o_htrans, TI);
        check("beats_issued", na, exp_err ? err_beat + 1 : nb);
        break;
      end
      if (stop_after != 0 && cycles > stop_after) break;
      if (cycles > 300) begin
        check("timeout_done", o_done, 1);
        break;
      end
      exp_rdv = 1'b0;
      hr = 1'b1;
      hp = 1'b0;
      if (dp >= 0) begin
        if (dp == err_beat) begin
          hp = 1'b1;
          hr = aborted;
        end else if (dpw > 0) begin
          hr = 1'b0;
          dpw--;
        end
        i_hrdata = dat[dp];
      end else begin
        i_hrdata = $urandom;
      end
      i_hready = hr;
      i_hresp = hp;
      issuing = !aborted && na < nb;
      if (!issuing || !wr) begin
        wv = 1'b0;
      end else if (!wv) begin
        if (na == gap_beat && gap > 0) begin
          gap--;
        end else begin
          wv = rand_wv ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
      i_wr_valid = wv;
      i_wr_data = wv ? dat[na] : $urandom;
      #1;
      ea = start + 32'(na) * (32'd1 << sc);
      if (hp || !issuing) et = TI;
      else if (wr && !wv) et = (na == 0) ? TI : TB;
      else et = (na == 0 || ea[9:0] == 10'd0) ? TN : TS;
      check("htrans", o_htrans, et);
      if (et != TI) begin
        check("haddr", o_haddr, ea);
        check("hwrite", o_hwrite, wr);
        check("hsize", o_hsize, sc);
        check("hburst", o_hburst, (len == 0) ? 0 : 1);
      end
      check("wr_ready", o_wr_ready, wr && issuing && wv && hr && !hp);
      if (dp >= 0 && wr) check("hwdata", o_hwdata, dat[dp]);
      if (et == TB && hr) busy++;
      if (hp && !hr) begin
        aborted = 1'b1;
      end else if (hp && hr) begin
        exp_done = 1'b1;
        exp_err = 1'b1;
        dp = -1;
      end else if (hr) begin
        if (dp >= 0) begin
          if (!wr) begin
            exp_rdv = 1'b1;
            exp_rd = dat[dp];
          end
          if (dp == nb - 1) begin
            exp_done = 1'b1;
            exp_err = 1'b0;
          end
        end
        if (et == TN || et == TS) begin
          dp = na;
          na++;
          wv = 1'b0;
          dpw = (waits < 0) ? $urandom_range(0, 2) : waits;
        end else begin
          dp = -1;
        end
      end
      tick();
    end
  endtask

  initial begin
    int cyc, bsy, ln, eb;
    logic [2:0] sz;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rstn = 1'b1;
    tick();

    fill(1'b1, 32'hA5A5_A5A5);
    run_req(32'h100, 1'b1, 3'd2, 0, 1, -1, 1'b0, -1, 0, 0, cyc, bsy);

    fill(1'b1, 32'd1);
    run_req(32'h200, 1'b0, 3'd2, 3, 0, -1, 1'b0, -1, 0, 0, cyc, bsy);
    check("incr4_cycles", cyc, 6);

    fill(1'b0, '0);
    run_req(32'h200, 1'b1, 3'd2, 3, 0, -1, 1'b0, 2, 2, 0, cyc, bsy);
    check("busy_cycles", bsy, 2);

    fill(1'b0, '0);
    run_req(32'h3F8, 1'b0, 3'd2, 3, 0, -1, 1'b0, -1, 0, 0, cyc, bsy);

    fill(1'b0, '0);
    run_req(32'h1000, 1'b1, 3'd2, 7, 0, 1, 1'b0, -1, 0, 0, cyc, bsy);

    // Reset in the middle of a burst, then a clean request
    fill(1'b0, '0);
    run_req(32'h2000, 1'b1, 3'd2, 7, 0, -1, 1'b0, -1, 0, 3, cyc, bsy);
    i_valid = 1'b0; i_wr_valid = 1'b0; i_hready = 1'b1; i_hresp = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    #2;
    rstn = 1'b1;
    tick();
    fill(1'b0, '0);
    run_req(32'h2000, 1'b0, 3'd2, 5, -1, -1, 1'b0, -1, 0, 0, cyc, bsy);

    for (int r = 0; r < 24; r++) begin
      sz = 3'($urandom_range(0, 7));
      ln = $urandom_range(0, 15);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ln) : -1;
      a = ($urandom & 32'h7FFF_FC00) + 32'd1024 - 32'($urandom_range(0, 96));
      a = a & ~((32'd1 << sz) - 32'd1);
      fill(1'b0, '0);
      run_req(a, 1'($urandom_range(0, 1)), sz, ln, -1, eb, 1'b1, -1, 0, 0, cyc, bsy);
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
